// File: rtl/bist_pkg.sv
// bist_pkg: shared types, LFSR polynomial and step function
// for the BIST link tester slice.
package bist_pkg;

  typedef enum logic [1:0] {
    LFSR    = 2'd0,
    WALK    = 2'd1,
    CHECKER = 2'd2,
    SOLID   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    SEND    = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  // Right-shifting Galois step: taps are XORed in when bit 0 falls out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/bist_link_tester_if.sv
// bist_link_tester_if: physical-link bundle (functional in, link out,
// loopback in); master = tester, slave = router/PHY side.
interface bist_link_tester_if #(
  parameter int W = 70
);
  logic [W-1:0] input_channels;
  logic [W-1:0] output_channels;
  logic [W-1:0] loopback_channels;

  modport master (
    input  input_channels,
    input  loopback_channels,
    output output_channels
  );

  modport slave (
    output input_channels,
    output loopback_channels,
    input  output_channels
  );
endinterface

// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: LFSR + case counter; ports clk, load (start run,
// latch mode), step (next case), mode_in, pattern, last (k == cases-1).
module bist_pattern_gen
  import bist_pkg::*;
#(
  parameter int          W     = 70,
  parameter logic [31:0] SEED  = 32'hdeadbeef,
  parameter int          CASES = 1000
) (
  input  logic         clk,
  input  logic         load,
  input  logic         step,
  input  mode_e        mode_in,
  output logic [W-1:0] pattern,
  output logic         last
);

  localparam logic [31:0] SEED_EFF =
    (SEED == 32'h0) ? 32'h1 : SEED;
  localparam int WW = (W > 1) ? $clog2(W) : 1;

  mode_e          mode_q;
  logic [31:0]    lfsr;
  logic [31:0]    k;
  // k mod W, kept as its own wrapping counter to avoid a divider
  logic [WW-1:0]  walk;

  always_ff @(posedge clk) begin
    if (load) begin
      mode_q <= mode_in;
      lfsr   <= SEED_EFF;
      k      <= '0;
      walk   <= '0;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
      k    <= k + 32'd1;
      walk <= (walk == WW'(W - 1)) ? '0 : walk + WW'(1);
    end
  end

  assign last = (k == 32'(CASES - 1));

  always_comb begin
    pattern = '0;
    unique case (mode_q)
      LFSR:
        for (int i = 0; i < W; i++)
          pattern[i] = lfsr[i % 32];
      WALK:
        pattern[walk] = 1'b1;
      CHECKER:
        for (int i = 0; i < W; i++)
          pattern[i] = k[0] ^ i[0];
      SOLID:
        pattern = {W{k[0]}};
    endcase
  end

endmodule

// File: rtl/bist_link_tester.sv
// bist_link_tester: BIST sender/checker; ports clk, reset, restart, mode,
// link (if master), ready, pass, error_mask, error_count.
module bist_link_tester
  import bist_pkg::*;
#(
  parameter int          TEST_CHANNELS    = 70,
  parameter logic [31:0] SEED             = 32'hdeadbeef,
  parameter int          TEST_CASES       = 1000,
  parameter int          LOOPBACK_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     restart,
  input  logic [1:0]               mode,
  bist_link_tester_if.master       link,
  output logic                     ready,
  output logic                     pass,
  output logic [TEST_CHANNELS-1:0] error_mask,
  output logic [15:0]              error_count
);

  localparam int W = TEST_CHANNELS;
  localparam int L = LOOPBACK_LATENCY;

  state_e       state;
  logic [31:0]  drain_cnt;
  logic         start;
  logic         last;
  logic [W-1:0] pattern;
  logic [W-1:0] exp_d;
  logic         vld_d;
  logic [W-1:0] diff;

  // A run starts on leaving RESET_S or on restart while DONE.
  assign start = (state == RESET_S) ||
                 (state == DONE && restart);

  bist_pattern_gen #(
    .W     (W),
    .SEED  (SEED),
    .CASES (TEST_CASES)
  ) u_gen (
    .clk     (clk),
    .load    (reset || start),
    .step    (state == SEND),
    .mode_in (mode_e'(mode)),
    .pattern (pattern),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RESET_S;
      ready     <= 1'b0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        RESET_S: begin
          state <= SEND;
          ready <= 1'b0;
        end
        SEND:
          if (last) begin
            drain_cnt <= '0;
            if (L == 0) begin
              state <= DONE;
              ready <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        DRAIN:
          if (drain_cnt == 32'(L - 1)) begin
            state <= DONE;
            ready <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 32'd1;
          end
        DONE:
          if (restart) begin
            state <= SEND;
            ready <= 1'b0;
          end
      endcase
    end
  end

  if (L == 0) begin : g_nodly
    assign exp_d = pattern;
    assign vld_d = (state == SEND);
  end else begin : g_dly
    logic [W-1:0] pipe_d [L];
    logic         pipe_v [L];

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int j = 0; j < L; j++) begin
          pipe_v[j] <= 1'b0;
          pipe_d[j] <= '0;
        end
      end else begin
        pipe_v[0] <= (state == SEND);
        pipe_d[0] <= pattern;
        for (int j = 1; j < L; j++) begin
          pipe_v[j] <= pipe_v[j-1];
          pipe_d[j] <= pipe_d[j-1];
        end
      end
    end

    assign exp_d = pipe_d[L-1];
    assign vld_d = pipe_v[L-1];
  end

  assign diff = link.loopback_channels ^ exp_d;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      error_mask  <= '0;
      error_count <= '0;
    end else if (vld_d && state != DONE && diff != '0) begin
      error_mask <= error_mask | diff;
      if (error_count != 16'hFFFF)
        error_count <= error_count + 16'd1;
    end
  end

  assign pass = ready && (error_mask == '0);

  always_comb begin
    link.output_channels = '0;
    unique case (state)
      SEND:    link.output_channels = pattern;
      DONE:    link.output_channels = link.input_channels;
      RESET_S,
      DRAIN:   link.output_channels = '0;
    endcase
  end

endmodule

// File: tb/tb_bist_link_tester.sv
// tb_bist_link_tester: table-driven runs on a default instance plus
// hand sequences for walking-one, reset abort and count saturation.
module tb_bist_link_tester;
  import bist_pkg::*;

  localparam int W = 70;
  localparam logic [31:0] TB_SEED = 32'hdeadbeef;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_next(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ 32'h80200003;
    return s >> 1;
  endfunction

  function automatic logic [W-1:0] m_pat(input logic [1:0] m,
                                         input int k,
                                         input logic [31:0] lf);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < W; i++)
      case (m)
        2'd0:    p[i] = lf[i % 32];
        2'd1:    p[i] = (i == k % W);
        2'd2:    p[i] = ((i + k) % 2) == 1;
        default: p[i] = (k % 2) == 1;
      endcase
    return p;
  endfunction

  function automatic int bit5_count(input int n);
    logic [31:0] lf;
    int c;
    lf = TB_SEED;
    c = 0;
    for (int k = 0; k < n; k++) begin
      c += int'(lf[5]);
      lf = m_next(lf);
    end
    return c;
  endfunction

  // ---------------- instance 0: default parameters
  logic         rst0, rs0;
  logic [1:0]   md0;
  logic         rdy0, ps0;
  logic [W-1:0] em0;
  logic [15:0]  ec0;
  int           dly0 = 2;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] h01, h02, h03;
  bist_link_tester_if #(.W(W)) lnk0();

  always @(posedge clk) begin
    h01 <= lnk0.output_channels;
    h02 <= h01;
    h03 <= h02;
  end
  assign lnk0.loopback_channels = ((dly0 == 3) ? h03 : h02) & ~stuck0;

  bist_link_tester u0 (
    .clk(clk), .reset(rst0), .restart(rs0), .mode(md0),
    .link(lnk0), .ready(rdy0), .pass(ps0),
    .error_mask(em0), .error_count(ec0)
  );

  // ---------------- instance 1: 70 cases, latency 1
  logic         rst1;
  logic         rs1 = 1'b0;
  logic [1:0]   md1 = 2'd1;
  logic         rdy1, ps1;
  logic [W-1:0] em1;
  logic [15:0]  ec1;
  logic [W-1:0] h11;
  bist_link_tester_if #(.W(W)) lnk1();

  always @(posedge clk) h11 <= lnk1.output_channels;
  assign lnk1.loopback_channels = h11;

  bist_link_tester #(
    .TEST_CASES(70), .LOOPBACK_LATENCY(1)
  ) u1 (
    .clk(clk), .reset(rst1), .restart(rs1), .mode(md1),
    .link(lnk1), .ready(rdy1), .pass(ps1),
    .error_mask(em1), .error_count(ec1)
  );

  // ---------------- instance 2: 70000 cases, latency 0, inverted loopback
  logic         rst2, rs2;
  logic [1:0]   md2;
  logic         rdy2, ps2;
  logic [W-1:0] em2;
  logic [15:0]  ec2;
  bist_link_tester_if #(.W(W)) lnk2();

  assign lnk2.loopback_channels = ~lnk2.output_channels;

  bist_link_tester #(
    .TEST_CASES(70000), .LOOPBACK_LATENCY(0)
  ) u2 (
    .clk(clk), .reset(rst2), .restart(rs2), .mode(md2),
    .link(lnk2), .ready(rdy2), .pass(ps2),
    .error_mask(em2), .error_count(ec2)
  );

  typedef struct {
    string        nm;
    logic [1:0]   m;
    int           d;
    logic [W-1:0] st;
    logic         ep;
    logic [W-1:0] emask;
    logic [15:0]  ecnt;
  } vec_t;

  vec_t tbl [5];

  // kind 0: start by releasing reset, kind 1: restart pulse
  task automatic run0(input vec_t v, input int kind);
    logic [31:0]  lf;
    logic [W-1:0] ex;
    int           n, bad;
    bit           got;
    @(negedge clk);
    md0 = v.m;
    dly0 = v.d;
    stuck0 = v.st;
    lnk0.input_channels = '0;
    if (kind == 0) rst0 = 1'b0;
    else rs0 = 1'b1;
    @(posedge clk); #1;
    rs0 = 1'b0;
    md0 = ~v.m;
    lf = TB_SEED;
    n = 0;
    bad = 0;
    got = 1'b0;
    while (n <= 1100) begin
      if (rdy0) begin
        got = 1'b1;
        break;
      end
      ex = (n < 1000) ? m_pat(v.m, n, lf) : '0;
      if (lnk0.output_channels !== ex) bad++;
      lf = m_next(lf);
      @(posedge clk); #1;
      n++;
    end
    check({v.nm, "_pattern_bad_cycles"}, W'(bad), W'(0));
    check({v.nm, "_ready_cycle"}, got ? W'(n) : '1, W'(1002));
    check({v.nm, "_pass"}, W'(ps0), W'(v.ep));
    check({v.nm, "_error_mask"}, em0, v.emask);
    check({v.nm, "_error_count"}, W'(ec0), W'(v.ecnt));
    lnk0.input_channels = 70'hcafecafe;
    #1;
    check({v.nm, "_passthrough"}, lnk0.output_channels, 70'hcafecafe);
    lnk0.input_channels = '0;
  endtask

  task automatic seq_u0();
    vec_t rr;
    tbl[0] = '{"lfsr_clean", 2'd0, 2, '0, 1'b1, '0, 16'd0};
    tbl[1] = '{"lfsr_bit5", 2'd0, 2, 70'h20, 1'b0, 70'h20,
               16'(bit5_count(1000))};
    tbl[2] = '{"chk_dly3", 2'd2, 3, '0, 1'b0, {W{1'b1}}, 16'd1000};
    tbl[3] = '{"solid", 2'd3, 2, '0, 1'b1, '0, 16'd0};
    tbl[4] = '{"walk", 2'd1, 2, '0, 1'b1, '0, 16'd0};

    rst0 = 1'b1;
    rs0 = 1'b0;
    md0 = 2'd0;
    lnk0.input_channels = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", lnk0.output_channels, '0);
    check("rst_ready", W'(rdy0), W'(0));
    check("rst_pass", W'(ps0), W'(0));
    check("rst_mask", em0, '0);
    check("rst_count", W'(ec0), W'(0));

    for (int i = 0; i < 5; i++)
      run0(tbl[i], (i == 0) ? 0 : 1);

    // abort a run at case 500 with a stuck bit, then rerun clean
    @(negedge clk);
    md0 = 2'd0;
    dly0 = 2;
    stuck0 = 70'h20;
    rs0 = 1'b1;
    @(posedge clk); #1;
    rs0 = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("abort_pre_count", W'(ec0), W'(bit5_count(498)));
    @(negedge clk);
    rst0 = 1'b1;
    stuck0 = '0;
    lnk0.input_channels = '1;
    @(posedge clk); #1;
    check("abort_rst_out", lnk0.output_channels, '0);
    check("abort_rst_ready", W'(rdy0), W'(0));
    check("abort_rst_mask", em0, '0);
    check("abort_rst_count", W'(ec0), W'(0));
    @(posedge clk);
    rr = '{"abort_rerun", 2'd0, 2, '0, 1'b1, '0, 16'd0};
    run0(rr, 0);
  endtask

  task automatic seq_u1();
    logic [W-1:0] one;
    int bad;
    one = W'(1);
    bad = 0;
    rst1 = 1'b1;
    lnk1.input_channels = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst1 = 1'b0;
    lnk1.input_channels = '0;
    @(posedge clk); #1;
    for (int k = 0; k < 70; k++) begin
      if (lnk1.output_channels !== (one << k)) bad++;
      @(posedge clk); #1;
    end
    check("walk70_onehot_bad", W'(bad), W'(0));
    check("walk70_drain_ready", W'(rdy1), W'(0));
    check("walk70_drain_out", lnk1.output_channels, '0);
    @(posedge clk); #1;
    check("walk70_ready", W'(rdy1), W'(1));
    check("walk70_pass", W'(ps1), W'(1));
    check("walk70_count", W'(ec1), W'(0));
    lnk1.input_channels = 70'hcafecafe;
    #1;
    check("walk70_passthrough", lnk1.output_channels, 70'hcafecafe);
  endtask

  task automatic seq_u2();
    int n;
    bit got;
    rst2 = 1'b1;
    rs2 = 1'b0;
    md2 = 2'd2;
    lnk2.input_channels = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    @(posedge clk); #1;
    n = 0;
    got = 1'b0;
    while (n <= 70100) begin
      if (rdy2) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    check("sat_ready_cycle", got ? W'(n) : '1, W'(70000));
    check("sat_count", W'(ec2), W'(16'hFFFF));
    check("sat_mask", em2, {W{1'b1}});
    check("sat_pass", W'(ps2), W'(0));
    @(negedge clk);
    md2 = 2'd3;
    rs2 = 1'b1;
    @(posedge clk); #1;
    rs2 = 1'b0;
    check("sat_restart_ready", W'(rdy2), W'(0));
    check("sat_restart_count", W'(ec2), W'(0));
    check("sat_restart_mask", em2, '0);
    check("solid_case0", lnk2.output_channels, '0);
    @(posedge clk); #1;
    check("solid_case1", lnk2.output_channels, {W{1'b1}});
    check("solid_count1", W'(ec2), W'(1));
  endtask

  initial begin
    fork
      seq_u0();
      seq_u1();
      seq_u2();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_link_tester.md
# bist_link_tester

Parametrised successor to the single-mode BIST sender. It drives selectable test patterns onto a TEST_CHANNELS-wide link for TEST_CASES cycles and checks the looped-back data against expected values with a configurable loopback latency. It records per-channel sticky errors and a mismatch count, then switches the link to functional pass-through. It sits between a router output port and the physical channel wires.

## Interface
- TEST_CHANNELS, 70: link width in bits.
- SEED, 32'hdeadbeef: LFSR seed; 0 is replaced by 32'h1.
- TEST_CASES, 1000: number of pattern cycles per run, ≥1.
- LOOPBACK_LATENCY, 2: cycles from output_channels to matching loopback_channels, ≥0.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- restart  in  1  single-cycle pulse; starts a new run, honoured only in DONE.
- mode  in  2  pattern select, sampled on the cycle a run starts.
- input_channels  in  TEST_CHANNELS  functional payload, passed through after the test.
- loopback_channels  in  TEST_CHANNELS  returned link data.
- output_channels  out  TEST_CHANNELS  link drive.
- ready  out  1  test complete, link in pass-through.
- pass  out  1  ready && error_mask == 0.
- error_mask  out  TEST_CHANNELS  sticky per-channel mismatch flags.
- error_count  out  16  mismatching cycles, saturates at 16'hFFFF.

## Operation
- FSM states: RESET_S → SEND → DRAIN → DONE.
  - RESET_S is held while reset=1; the FSM leaves it on the first cycle with reset=0.
  - SEND lasts TEST_CASES cycles; case index k counts 0..TEST_CASES-1.
  - DRAIN lasts LOOPBACK_LATENCY cycles and is skipped if that is 0.
  - DONE holds until restart=1, which returns the FSM to SEND.
  - A run start clears error_mask, error_count, the LFSR (reloaded to SEED) and k.
- Patterns, bit i of case k:
  - mode 0 LFSR: lfsr[i mod 32]. Galois LFSR, polynomial 32'h80200003, advances once per case.
  - mode 1 walking-one: 1 iff i == k mod TEST_CHANNELS.
  - mode 2 checkerboard: (i+k) & 1.
  - mode 3 solid: all bits = k & 1, so case 0 is all-zero.
- Checking:
  - Expected pattern and a valid bit enter a LOOPBACK_LATENCY-deep delay line.
  - Compare loopback_channels against the delayed expected value when the delayed valid bit is 1.
  - A mismatch ORs the differing bits into error_mask and increments error_count (saturating).
  - With latency 0, the compare is combinational against the current pattern.
- output_channels:
  - SEND: the pattern.
  - DRAIN: all-zero.
  - DONE: input_channels, combinational pass-through.
- mode changes during a run are ignored.

## Timing
- During reset, and on the cycle after reset is released, every output is 0 and the delay line is cleared.
- With reset deasserted at edge E0, case k appears on output_channels after edge E0+k.
- ready rises after edge E0+TEST_CASES+LOOPBACK_LATENCY; default is cycle 1002.
- Reset mid-run aborts the run, clears all state and restarts automatically on release.
- restart outside DONE is ignored.
- After restart, ready drops on the next edge and the timing above repeats with E0 = the restart edge.
- Loopback data is compared on the last DRAIN cycle.
- loopback_channels is not checked in DONE.

## Structure
- Package bist_pkg holds:
  - the mode_e enum (LFSR, WALK, CHECKER, SOLID);
  - the state_e enum;
  - LFSR_POLY = 32'h80200003;
  - function lfsr_next.
- Sub-module bist_pattern_gen owns the LFSR and case counter and produces the pattern for the current mode and k.
- The top module holds the FSM, the delay line, the checker and the output mux.

## Test plan
- Default parameters, mode 0, loopback = output delayed 2 cycles → ready at cycle 1002, pass=1, error_mask=0, error_count=0. Then input_channels=70'hcafecafe appears unchanged on output_channels.
- Same as above, but loopback bit 5 stuck at 0 → error_mask = 70'h20, pass=0. error_count equals the number of cases with expected bit 5 = 1, checked against a model of the same LFSR.
- TEST_CASES=70, mode 1 → output_channels is one-hot at bit k on each case k. After ready, output_channels matches input_channels.
- Reset pulsed at case 500 → outputs go to 0 and the run restarts from SEED. ready rises 1002 cycles after reset is released, with no errors carried over.
- Loopback delayed 3 cycles instead of 2, mode 2 → all 70 error_mask bits set, pass=0, error_count=1000.
- In DONE, restart with mode 3, then restart again with error_count at its limit (TEST_CASES=70000, all-wrong loopback) → solid patterns alternate 0/1, and error_count saturates at 16'hFFFF.
